// File: rtl/catch_scoreboard.sv
// Four-digit multiplexed seven-segment scoreboard for the catch game: decimal count, status glyph, hex best score.
// Optional leading-zero blanking of the tens digit via `define CATCH_SCOREBOARD_BLANK_EN.
module catch_scoreboard #(
    parameter int DIGIT_CYCLES = 4,
    parameter int FLASH_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       durum,
    input  logic [3:0] yakalama_sayisi,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       flash,
    output logic [3:0] high_score
);
    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES);
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [3:0]       score_reg;
    logic             durum_reg;
    logic [CNT_W-1:0] scan_cnt_reg;
    logic [1:0]       digit_idx_reg;
    logic [7:0]       flash_cnt_reg;
    logic [7:0]       flash_cnt_next;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;
    logic [3:0]       high_score_next;
    logic             tens;
    logic [3:0]       ones;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Count is limited to 0..15, so the tens digit is never more than 1.
    always_comb begin
        tens     = (score_reg >= 4'd10);
        ones     = tens ? (score_reg - 4'd10) : score_reg;
        seg_next = BLANK;
        case (digit_idx_reg)
            2'd0: seg_next = glyph(ones);
`ifdef CATCH_SCOREBOARD_BLANK_EN
            2'd1: seg_next = tens ? glyph(4'd1) : BLANK;
`else
            2'd1: seg_next = glyph({3'b000, tens});
`endif
            2'd2: seg_next = glyph({3'b000, durum_reg});
            default: seg_next = glyph(high_score);
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign an_next[gi] = (digit_idx_reg != 2'(gi));
        end
    endgenerate

    // An increase is judged against the previous sample, so a held value triggers only once.
    always_comb begin
        flash_cnt_next = flash_cnt_reg;
        if (yakalama_sayisi > score_reg)
            flash_cnt_next = FLASH_LOAD;
        else if (flash_cnt_reg != 8'd0)
            flash_cnt_next = flash_cnt_reg - 8'd1;
        high_score_next = (yakalama_sayisi > high_score) ? yakalama_sayisi : high_score;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_reg     <= 4'd0;
            durum_reg     <= 1'b0;
            scan_cnt_reg  <= '0;
            digit_idx_reg <= 2'd0;
            flash_cnt_reg <= 8'd0;
            seg           <= BLANK;
            an            <= 4'b1111;
            high_score    <= 4'd0;
        end else begin
            score_reg     <= yakalama_sayisi;
            durum_reg     <= durum;
            flash_cnt_reg <= flash_cnt_next;
            seg           <= seg_next;
            an            <= an_next;
            high_score    <= high_score_next;
            if (scan_cnt_reg == SCAN_LAST) begin
                scan_cnt_reg  <= '0;
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
        end
    end

    assign flash = (flash_cnt_reg != 8'd0);

endmodule

// File: tb/tb_catch_scoreboard.sv
// Randomized self-checking bench for catch_scoreboard against an interval/arithmetic reference model.
// Honours `define CATCH_SCOREBOARD_BLANK_EN when the design is built with blanking.
module tb_catch_scoreboard;
    localparam int DC = 4;
    localparam int FC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       durum;
    logic [3:0] yakalama_sayisi;
    logic [6:0] seg;
    logic [3:0] an;
    logic       flash;
    logic [3:0] high_score;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // reference model state: edges since release, previous sample, best, edge of last increase
    int         k;
    int         prev_score;
    int         prev_durum;
    int         hs_m;
    int         last_inc;
    logic [6:0] slot_seg [4];
    int         flash_hi_cnt;

    catch_scoreboard #(.DIGIT_CYCLES(DC), .FLASH_CYCLES(FC)) dut (
        .clk(clk),
        .rst(rst),
        .durum(durum),
        .yakalama_sayisi(yakalama_sayisi),
        .seg(seg),
        .an(an),
        .flash(flash),
        .high_score(high_score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; prev_score = 0; prev_durum = 0; hs_m = 0; last_inc = 0;
        for (int i = 0; i < 4; i++) slot_seg[i] = 7'h7f;
    endtask

    function automatic logic [6:0] tens_glyph(input int v);
`ifdef CATCH_SCOREBOARD_BLANK_EN
        return (v / 10 == 0) ? 7'h7f : glyph_tab[v / 10];
`else
        return glyph_tab[v / 10];
`endif
    endfunction

    // Per-edge comparison: what the outputs must be after edge k given input (y,d) sampled at it.
    task automatic check_cycle(input int y, input int d);
        int digit;
        logic [6:0] seg_exp;
        logic flash_exp;
        k++;
        digit = ((k - 1) / DC) % 4;
        case (digit)
            0: seg_exp = glyph_tab[prev_score % 10];
            1: seg_exp = tens_glyph(prev_score);
            2: seg_exp = glyph_tab[prev_durum];
            default: seg_exp = glyph_tab[hs_m];
        endcase
        if (y > prev_score) last_inc = k;
        if (y > hs_m) hs_m = y;
        flash_exp = (last_inc > 0) && (k - last_inc < FC);
        prev_score = y;
        prev_durum = d;
        chk("seg", int'(seg), int'(seg_exp));
        chk("an", int'(an), int'(~(4'b0001 << digit) & 4'hf));
        chk("flash", int'(flash), int'(flash_exp));
        chk("high_score", int'(high_score), hs_m);
        slot_seg[digit] = seg;
        if (flash) flash_hi_cnt++;
    endtask

    task automatic step(input logic [3:0] y, input logic d);
        yakalama_sayisi = y;
        durum = d;
        @(posedge clk);
        #1;
        check_cycle(int'(y), int'(d));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_seg"}, int'(seg), 'h7f);
        chk({tag, "_an"}, int'(an), 'hf);
        chk({tag, "_flash"}, int'(flash), 0);
        chk({tag, "_hs"}, int'(high_score), 0);
    endtask

    initial begin
        logic [3:0] cur_y;
        logic       cur_d;
        rst = 1'b0;
        durum = 1'b0;
        yakalama_sayisi = 4'd0;
        flash_hi_cnt = 0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_state("reset");
        end

        // release: first edge shows ones of 0 in slot 0
        rst = 1'b1;
        step(4'd0, 1'b0);
        chk("first_seg_lit", int'(seg), 'b1000000);
        chk("first_an_lit", int'(an), 'b1110);
        repeat (19) step(4'd0, 1'b0);

        // 0 -> 1: flash exactly FC cycles
        flash_hi_cnt = 0;
        repeat (20) step(4'd1, 1'b0);
        chk("inc_flash_len", flash_hi_cnt, 8);
        chk("inc_ones_lit", int'(slot_seg[0]), 'b1111001);
`ifdef CATCH_SCOREBOARD_BLANK_EN
        chk("inc_tens_lit", int'(slot_seg[1]), 'b1111111);
`else
        chk("inc_tens_lit", int'(slot_seg[1]), 'b1000000);
`endif
        chk("inc_hs_lit", int'(high_score), 1);

        // count 12 with durum=1
        repeat (20) step(4'd12, 1'b1);
        chk("c12_ones_lit", int'(slot_seg[0]), 'b0100100);
        chk("c12_tens_lit", int'(slot_seg[1]), 'b1111001);
        chk("c12_durum_lit", int'(slot_seg[2]), 'b1111001);
        chk("c12_hs_lit", int'(slot_seg[3]), 'b1000110);

        // retrigger at cycle 0 and cycle 5
        flash_hi_cnt = 0;
        repeat (5) step(4'd13, 1'b1);
        repeat (20) step(4'd14, 1'b1);
        chk("retrig_flash_len", flash_hi_cnt, 13);

        // 15 then wrap to 0: no flash, best kept
        repeat (12) step(4'd15, 1'b0);
        flash_hi_cnt = 0;
        repeat (20) step(4'd0, 1'b0);
        chk("wrap_flash_len", flash_hi_cnt, 0);
        chk("wrap_hs_lit", int'(high_score), 15);
        chk("wrap_ones_lit", int'(slot_seg[0]), 'b1000000);

        // randomized traffic
        cur_y = 4'd0;
        cur_d = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur_y = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) cur_y = cur_y + 4'd1;
            if ($urandom_range(0, 9) == 0) cur_d = ~cur_d;
            step(cur_y, cur_d);
        end

        // asynchronous reset in the middle of a flash at count 9
        repeat (5) step(4'd3, 1'b0);
        repeat (3) step(4'd9, 1'b1);
        chk("pre_rst_flash_lit", int'(flash), 1);
        #2 rst = 1'b0;
        #1 check_reset_state("async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_state("hold");
        end
        rst = 1'b1;
        model_reset();
        flash_hi_cnt = 0;
        step(4'd9, 1'b1);
        chk("post_rst_flash_lit", int'(flash), 1);
        repeat (15) step(4'd9, 1'b1);
        chk("post_rst_flash_len", flash_hi_cnt, 8);
        chk("post_rst_hs_lit", int'(high_score), 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
